// File: rtl/vec_sequencer_pkg.sv
// Shared state encoding and default sizing (c5315 netlist) for the vector sequencer.
package vec_sequencer_pkg;

    localparam int          VEC_W_DEF  = 178;
    localparam int          OUT_W_DEF  = 123;
    localparam int          ADDR_W_DEF = 16;
    localparam logic [31:0] POLY_DEF   = 32'h04C11DB7;
    localparam logic [31:0] SEED_DEF   = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_FIN
    } state_t;

    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] fold,
                                              input logic [31:0] poly);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ fold;
    endfunction

endpackage

// File: rtl/vec_sequencer_misr.sv
// Folds a wide capture word into 32 bits (zero-padded top chunk) and shifts it into a MISR.
module vec_misr
    import vec_sequencer_pkg::*;
#(
    parameter int          IN_W = OUT_W_DEF,
    parameter logic [31:0] POLY = POLY_DEF,
    parameter logic [31:0] SEED = SEED_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic [IN_W-1:0] i_data,
    output logic [31:0]     o_sig
);

    localparam int NCH   = (IN_W + 31) / 32;
    localparam int PAD_W = NCH * 32;

    logic [PAD_W-1:0] w_padded;
    logic [31:0]      w_fold;
    logic [31:0]      r_sig;

    assign w_padded = PAD_W'(i_data);

    always_comb begin
        w_fold = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fold = w_fold ^ w_padded[i*32 +: 32];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig <= SEED;
        end else if (i_clear) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, w_fold, POLY);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/vec_sequencer.sv
// Streams vectors from a synchronous memory into a combinational DUT, waits a settle time,
// hands the DUT outputs to a valid/ready sink and compresses them into a MISR signature.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH   | read strobe to vector memory
//   LOAD    | memory data registered onto dut_in
//   SETTLE  | counting down settle cycles
//   CAPTURE | capture offered to the sink until accepted
//   FIN     | run complete, done pulses next cycle
module vec_sequencer
    import vec_sequencer_pkg::*;
#(
    parameter int          VEC_W  = VEC_W_DEF,
    parameter int          OUT_W  = OUT_W_DEF,
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter logic [31:0] POLY   = POLY_DEF,
    parameter logic [31:0] SEED   = SEED_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_num_vec,
    input  logic [15:0]       i_num_loops,
    input  logic [7:0]        i_settle,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [VEC_W-1:0]  i_mem_rdata,
    output logic [VEC_W-1:0]  o_dut_in,
    input  logic [OUT_W-1:0]  i_dut_out,
    output logic              o_cap_valid,
    input  logic              i_cap_ready,
    output logic [OUT_W-1:0]  o_cap_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [31:0]       o_signature,
    output logic [31:0]       o_vec_cnt
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_num_vec;
    logic [15:0]       r_num_loops;
    logic [7:0]        r_settle;
    logic [7:0]        r_settle_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_loop;
    logic              r_mem_rd;
    logic [VEC_W-1:0]  r_dut_in;
    logic              r_cap_valid;
    logic              r_cap_first;
    logic [OUT_W-1:0]  r_cap_data;
    logic              r_done;
    logic              r_aborted;
    logic [31:0]       r_vec_cnt;

    logic              w_handshake;
    logic              w_misr_clear;
    logic [OUT_W-1:0]  w_cap_data;

    // First capture cycle shows dut_out live so a zero settle still gets a full cycle after
    // dut_in changes; from then on the registered copy holds it stable under backpressure.
    assign w_cap_data   = r_cap_first ? i_dut_out : r_cap_data;
    assign w_handshake  = (r_state == S_CAPTURE) && r_cap_valid && i_cap_ready && !i_abort;
    assign w_misr_clear = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_num_vec    <= '0;
            r_num_loops  <= '0;
            r_settle     <= '0;
            r_settle_cnt <= '0;
            r_addr       <= '0;
            r_loop       <= '0;
            r_mem_rd     <= 1'b0;
            r_dut_in     <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_first  <= 1'b0;
            r_cap_data   <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_vec_cnt    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_mem_rd  <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                r_state     <= S_IDLE;
                r_aborted   <= 1'b1;
                r_cap_valid <= 1'b0;
                r_cap_first <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_num_vec   <= i_num_vec;
                            r_num_loops <= i_num_loops;
                            r_settle    <= i_settle;
                            r_vec_cnt   <= '0;
                            r_addr      <= '0;
                            r_loop      <= '0;
                            if (i_num_vec == '0 || i_num_loops == '0) begin
                                r_state <= S_FIN;
                            end else begin
                                r_state  <= S_FETCH;
                                r_mem_rd <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: r_state <= S_LOAD;
                    S_LOAD: begin
                        r_dut_in <= i_mem_rdata;
                        if (r_settle == '0) begin
                            r_state     <= S_CAPTURE;
                            r_cap_valid <= 1'b1;
                            r_cap_first <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                        if (r_settle_cnt == 8'd1) begin
                            r_state     <= S_CAPTURE;
                            r_cap_valid <= 1'b1;
                            r_cap_first <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        if (r_cap_first) begin
                            r_cap_data  <= i_dut_out;
                            r_cap_first <= 1'b0;
                        end
                        if (w_handshake) begin
                            r_cap_valid <= 1'b0;
                            r_vec_cnt   <= r_vec_cnt + 32'd1;
                            if (r_addr < r_num_vec - ADDR_W'(1)) begin
                                r_addr   <= r_addr + ADDR_W'(1);
                                r_state  <= S_FETCH;
                                r_mem_rd <= 1'b1;
                            end else if (r_loop < r_num_loops - 16'd1) begin
                                r_addr   <= '0;
                                r_loop   <= r_loop + 16'd1;
                                r_state  <= S_FETCH;
                                r_mem_rd <= 1'b1;
                            end else begin
                                r_state <= S_FIN;
                            end
                        end
                    end
                    S_FIN: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    vec_misr #(
        .IN_W (OUT_W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_misr_clear),
        .i_en    (w_handshake),
        .i_data  (w_cap_data),
        .o_sig   (o_signature)
    );

    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_addr;
    assign o_dut_in    = r_dut_in;
    assign o_cap_valid = r_cap_valid;
    assign o_cap_data  = w_cap_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;
    assign o_vec_cnt   = r_vec_cnt;

endmodule

// File: tb/tb_vec_sequencer.sv
// Self-checking bench: random vector memory, pass-through DUT, and a run-level reference model.
module tb_vec_sequencer;

    localparam int          VEC_W  = 178;
    localparam int          OUT_W  = 123;
    localparam int          ADDR_W = 16;
    localparam logic [31:0] POLY   = 32'h04C11DB7;
    localparam logic [31:0] SEED   = 32'hFFFFFFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] num_vec = '0;
    logic [15:0]       num_loops = '0;
    logic [7:0]        settle = '0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [VEC_W-1:0]  mem_rdata = '0;
    logic [VEC_W-1:0]  dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              cap_valid;
    logic              cap_ready = 1'b1;
    logic [OUT_W-1:0]  cap_data;
    logic              busy, done, aborted;
    logic [31:0]       signature, vec_cnt;

    logic [VEC_W-1:0]  mem [8];
    int                q_addr[$];
    logic [OUT_W-1:0]  q_cap[$];
    int                stall_changes;
    int                n_vec = 0;
    int                n_miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[2:0]];

    assign dut_out = dut_in[VEC_W-1 -: OUT_W];

    vec_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_num_vec(num_vec), .i_num_loops(num_loops), .i_settle(settle),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
        .o_dut_in(dut_in), .i_dut_out(dut_out),
        .o_cap_valid(cap_valid), .i_cap_ready(cap_ready), .o_cap_data(cap_data),
        .o_busy(busy), .o_done(done), .o_aborted(aborted),
        .o_signature(signature), .o_vec_cnt(vec_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [OUT_W-1:0] exp_cap(input int k, input int nv);
        logic [VEC_W-1:0] v;
        v = mem[k % nv];
        return v[VEC_W-1 -: OUT_W];
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] sig, input logic [OUT_W-1:0] d);
        logic [127:0] p;
        logic [31:0]  f;
        p = '0;
        p[OUT_W-1:0] = d;
        f = 32'h0;
        for (int c = 0; c < 4; c++) f = f ^ p[c*32 +: 32];
        return (sig << 1) ^ (sig[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [31:0] exp_sig(input int nv, input int ncap);
        logic [31:0] s;
        s = SEED;
        for (int k = 0; k < ncap; k++) s = misr_ref(s, exp_cap(k, nv));
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic fill_mem();
        logic [191:0] t;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 6; c++) t[c*32 +: 32] = $urandom;
            mem[i] = t[VEC_W-1:0];
        end
    endtask

    task automatic start_run(input int nv, input int nl, input int st);
        num_vec   = ADDR_W'(nv);
        num_loops = 16'(nl);
        settle    = 8'(st);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Runs cycle by cycle from the cycle after start; cyc counts edges since start was sampled.
    task automatic watch(input int limit, input int stall_idx, input int stall_len,
                         input int abort_idx, output int done_at);
        int cyc, ncap, stalls;
        logic abort_sent;
        logic [OUT_W-1:0] held_data;
        logic [VEC_W-1:0] held_in;
        cyc = 1; ncap = 0; stalls = 0; abort_sent = 1'b0; done_at = -1;
        held_data = '0; held_in = '0;
        q_addr.delete(); q_cap.delete(); stall_changes = 0;
        while (cyc <= limit) begin
            if (mem_rd) q_addr.push_back(int'(mem_addr));
            if (done) begin
                done_at = cyc;
                break;
            end
            if (aborted) break;
            cap_ready = 1'b1;
            abort     = 1'b0;
            if (cap_valid) begin
                if (ncap == abort_idx && !abort_sent) begin
                    abort = 1'b1;
                    abort_sent = 1'b1;
                end else if (ncap == stall_idx && stalls < stall_len) begin
                    if (stalls == 0) begin
                        held_data = cap_data;
                        held_in   = dut_in;
                    end else if (cap_data !== held_data || dut_in !== held_in) begin
                        stall_changes++;
                    end
                    cap_ready = 1'b0;
                    stalls++;
                end else begin
                    if (ncap == stall_idx && stall_len > 0 &&
                        (cap_data !== held_data || dut_in !== held_in)) stall_changes++;
                    q_cap.push_back(cap_data);
                    ncap++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        cap_ready = 1'b1;
        abort     = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (mem_rd !== 1'b0 || mem_addr !== '0) begin n_miss++; $display("FAIL reset_mem: rd %b addr %0d expected 0/0", mem_rd, mem_addr); end
        n_vec++; if (cap_valid !== 1'b0 || cap_data !== '0) begin n_miss++; $display("FAIL reset_cap: valid %b data %h expected 0", cap_valid, cap_data); end
        n_vec++; if (done !== 1'b0 || aborted !== 1'b0) begin n_miss++; $display("FAIL reset_pulses: done %b aborted %b expected 0", done, aborted); end
        n_vec++; if (signature !== SEED) begin n_miss++; $display("FAIL reset_sig: got %h expected %h", signature, SEED); end
        n_vec++; if (vec_cnt !== 32'h0 || dut_in !== '0) begin n_miss++; $display("FAIL reset_cnt: vec_cnt %0d dut_in %h expected 0", vec_cnt, dut_in); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d;
        fill_mem();
        start_run(3, 1, 2);
        watch(100, -1, 0, -1, d);
        n_vec++; if (d !== 17) begin n_miss++; $display("FAIL basic_done_cycle: got %0d expected 17", d); end
        n_vec++; if (q_cap.size() !== 3) begin n_miss++; $display("FAIL basic_cap_count: got %0d expected 3", q_cap.size()); end
        for (int k = 0; k < q_cap.size() && k < 3; k++) begin
            n_vec++; if (q_cap[k] !== exp_cap(k, 3)) begin n_miss++; $display("FAIL basic_cap%0d: got %h expected %h", k, q_cap[k], exp_cap(k, 3)); end
        end
        n_vec++; if (q_addr.size() !== 3) begin n_miss++; $display("FAIL basic_rd_count: got %0d expected 3", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < 3; k++) begin
            n_vec++; if (q_addr[k] !== k) begin n_miss++; $display("FAIL basic_addr%0d: got %0d expected %0d", k, q_addr[k], k); end
        end
        n_vec++; if (vec_cnt !== 32'd3) begin n_miss++; $display("FAIL basic_vec_cnt: got %0d expected 3", vec_cnt); end
        n_vec++; if (signature !== exp_sig(3, 3)) begin n_miss++; $display("FAIL basic_sig: got %h expected %h", signature, exp_sig(3, 3)); end
        n_vec++; if (dut_in !== mem[2] || busy !== 1'b0) begin n_miss++; $display("FAIL basic_hold: dut_in %h busy %b expected %h/0", dut_in, busy, mem[2]); end
    endtask

    task automatic test_loop();
        int d;
        fill_mem();
        start_run(2, 3, 0);
        watch(100, -1, 0, -1, d);
        n_vec++; if (d !== 20) begin n_miss++; $display("FAIL loop_done_cycle: got %0d expected 20", d); end
        n_vec++; if (q_addr.size() !== 6) begin n_miss++; $display("FAIL loop_rd_count: got %0d expected 6", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < 6; k++) begin
            n_vec++; if (q_addr[k] !== k % 2) begin n_miss++; $display("FAIL loop_addr%0d: got %0d expected %0d", k, q_addr[k], k % 2); end
        end
        for (int k = 0; k < q_cap.size() && k < 6; k++) begin
            n_vec++; if (q_cap[k] !== exp_cap(k, 2)) begin n_miss++; $display("FAIL loop_cap%0d: got %h expected %h", k, q_cap[k], exp_cap(k, 2)); end
        end
        n_vec++; if (vec_cnt !== 32'd6) begin n_miss++; $display("FAIL loop_vec_cnt: got %0d expected 6", vec_cnt); end
        n_vec++; if (signature !== exp_sig(2, 6)) begin n_miss++; $display("FAIL loop_sig: got %h expected %h", signature, exp_sig(2, 6)); end
    endtask

    task automatic test_backpressure();
        int d;
        fill_mem();
        start_run(3, 1, 2);
        watch(100, 1, 4, -1, d);
        n_vec++; if (d !== 21) begin n_miss++; $display("FAIL bp_done_cycle: got %0d expected 21", d); end
        n_vec++; if (stall_changes !== 0) begin n_miss++; $display("FAIL bp_stable: %0d changes during stall, expected 0", stall_changes); end
        for (int k = 0; k < q_cap.size() && k < 3; k++) begin
            n_vec++; if (q_cap[k] !== exp_cap(k, 3)) begin n_miss++; $display("FAIL bp_cap%0d: got %h expected %h", k, q_cap[k], exp_cap(k, 3)); end
        end
        n_vec++; if (signature !== exp_sig(3, 3) || vec_cnt !== 32'd3) begin n_miss++; $display("FAIL bp_result: sig %h cnt %0d expected %h/3", signature, vec_cnt, exp_sig(3, 3)); end
    endtask

    task automatic test_empty();
        int d;
        start_run(0, 3, 1);
        watch(20, -1, 0, -1, d);
        n_vec++; if (d !== 2) begin n_miss++; $display("FAIL empty_done_cycle: got %0d expected 2", d); end
        n_vec++; if (q_addr.size() !== 0) begin n_miss++; $display("FAIL empty_mem_rd: got %0d reads expected 0", q_addr.size()); end
        n_vec++; if (signature !== 32'hFFFFFFFF || vec_cnt !== 32'h0) begin n_miss++; $display("FAIL empty_result: sig %h cnt %0d expected ffffffff/0", signature, vec_cnt); end
        start_run(4, 0, 0);
        watch(20, -1, 0, -1, d);
        n_vec++; if (d !== 2 || q_addr.size() !== 0) begin n_miss++; $display("FAIL empty_loops: done %0d reads %0d expected 2/0", d, q_addr.size()); end
    endtask

    task automatic test_abort();
        int d;
        fill_mem();
        start_run(3, 1, 1);
        watch(100, -1, 0, 1, d);
        n_vec++; if (aborted !== 1'b1) begin n_miss++; $display("FAIL abort_pulse: got %b expected 1", aborted); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || d !== -1) begin n_miss++; $display("FAIL abort_idle: busy %b done %b done_at %0d expected 0/0/-1", busy, done, d); end
        n_vec++; if (cap_valid !== 1'b0 || mem_rd !== 1'b0) begin n_miss++; $display("FAIL abort_outputs: cap_valid %b mem_rd %b expected 0/0", cap_valid, mem_rd); end
        n_vec++; if (vec_cnt !== 32'd1) begin n_miss++; $display("FAIL abort_vec_cnt: got %0d expected 1", vec_cnt); end
        n_vec++; if (signature !== exp_sig(3, 1)) begin n_miss++; $display("FAIL abort_sig: got %h expected %h", signature, exp_sig(3, 1)); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++; if (aborted !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL abort_in_idle: aborted %b busy %b expected 0/0", aborted, busy); end
    endtask

    task automatic test_reset_mid();
        int d;
        fill_mem();
        start_run(3, 2, 5);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || mem_rd !== 1'b0 || cap_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_ctrl: busy %b rd %b valid %b expected 0", busy, mem_rd, cap_valid); end
        n_vec++; if (dut_in !== '0 || vec_cnt !== 32'h0 || mem_addr !== '0) begin n_miss++; $display("FAIL rstmid_regs: dut_in %h cnt %0d addr %0d expected 0", dut_in, vec_cnt, mem_addr); end
        n_vec++; if (signature !== SEED || done !== 1'b0 || aborted !== 1'b0) begin n_miss++; $display("FAIL rstmid_misc: sig %h done %b aborted %b expected %h/0/0", signature, done, aborted, SEED); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_run(2, 1, 1);
        watch(100, -1, 0, -1, d);
        n_vec++; if (d !== 10) begin n_miss++; $display("FAIL rstmid_rerun_done: got %0d expected 10", d); end
        n_vec++; if (q_addr.size() !== 2 || (q_addr.size() > 0 && q_addr[0] !== 0)) begin n_miss++; $display("FAIL rstmid_rerun_addr: reads %0d expected 2 starting at 0", q_addr.size()); end
        n_vec++; if (signature !== exp_sig(2, 2)) begin n_miss++; $display("FAIL rstmid_rerun_sig: got %h expected %h", signature, exp_sig(2, 2)); end
    endtask

    task automatic test_random();
        int d, nv, nl, st, total, sidx, slen, exp_d;
        for (int it = 0; it < 5; it++) begin
            fill_mem();
            nv    = int'($urandom_range(1, 5));
            nl    = int'($urandom_range(1, 3));
            st    = int'($urandom_range(0, 4));
            total = nv * nl;
            sidx  = int'($urandom_range(0, total - 1));
            slen  = int'($urandom_range(0, 5));
            exp_d = total * (3 + st) + 2 + slen;
            start_run(nv, nl, st);
            watch(400, sidx, slen, -1, d);
            n_vec++; if (d !== exp_d) begin n_miss++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d (nv %0d nl %0d st %0d stall %0d)", it, d, exp_d, nv, nl, st, slen); end
            n_vec++; if (vec_cnt !== 32'(total) || q_cap.size() !== total) begin n_miss++; $display("FAIL rand%0d_count: cnt %0d caps %0d expected %0d", it, vec_cnt, q_cap.size(), total); end
            for (int k = 0; k < q_cap.size() && k < total; k++) begin
                n_vec++; if (q_cap[k] !== exp_cap(k, nv)) begin n_miss++; $display("FAIL rand%0d_cap%0d: got %h expected %h", it, k, q_cap[k], exp_cap(k, nv)); end
            end
            n_vec++; if (signature !== exp_sig(nv, total)) begin n_miss++; $display("FAIL rand%0d_sig: got %h expected %h", it, signature, exp_sig(nv, total)); end
            n_vec++; if (stall_changes !== 0) begin n_miss++; $display("FAIL rand%0d_stable: %0d changes during stall, expected 0", it, stall_changes); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_backpressure();
        test_empty();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vec_sequencer.md
# vec_sequencer

Synthesizable stimulus controller for the combinational benchmark netlists (c5315 and siblings) used in the aging experiments. It streams input vectors from a synchronous vector memory into the DUT, holds each vector for a programmable settle time, and captures the DUT outputs through a valid/ready port for logging. It also compresses the outputs into a 32-bit MISR signature and loops the vector set a programmable number of times, for long stress runs.

## Interface
- VEC_W, 178, DUT input vector width (MSB drives first primary input)
- OUT_W, 123, DUT output width
- ADDR_W, 16, vector memory address width
- POLY, 32'h04C11DB7, MISR feedback polynomial
- SEED, 32'hFFFFFFFF, MISR initial value
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate current run
- num_vec  in  ADDR_W  vectors per pass (addresses 0..num_vec-1); latched at start
- num_loops  in  16  passes over the set; latched at start
- settle  in  8  wait cycles between apply and capture; latched at start
- mem_rd  out  1  vector memory read strobe
- mem_addr  out  ADDR_W  vector memory address
- mem_rdata  in  VEC_W  read data, valid exactly 1 cycle after mem_rd
- dut_in  out  VEC_W  registered DUT input vector
- dut_out  in  OUT_W  DUT outputs
- cap_valid  out  1  captured output available
- cap_ready  in  1  sink accepts capture
- cap_data  out  OUT_W  captured dut_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort
- signature  out  32  MISR value
- vec_cnt  out  32  captures accepted this run (wraps)

## Operation
- FSM states: IDLE, FETCH, LOAD, SETTLE, CAPTURE, FIN.
- IDLE + start: latch config; clear vec_cnt, signature<=SEED, addr<=0, loop<=0. If num_vec==0 or num_loops==0, go to FIN; otherwise go to FETCH.
- FETCH: mem_rd=1, mem_addr=addr; go to LOAD.
- LOAD: dut_in<=mem_rdata. If settle==0, go to CAPTURE; otherwise load the settle counter and go to SETTLE.
- SETTLE: decrement the counter; go to CAPTURE when it reaches 1.
- CAPTURE: on the first cycle in this state, register dut_out into cap_data and raise cap_valid.
  - cap_valid and cap_data are held stable until cap_ready.
  - On the handshake: MISR update, vec_cnt+1, cap_valid drops.
  - Then, if addr<num_vec-1: addr+1, go to FETCH.
  - Else if loop<num_loops-1: addr<=0, loop+1, go to FETCH.
  - Else: go to FIN.
- FIN: done=1 for one cycle; go to IDLE.
- MISR update: fold = XOR of the 32-bit chunks of cap_data, with the top chunk zero-padded. sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- abort in any non-IDLE state:
  - next state is IDLE; aborted pulses; done is not asserted.
  - cap_valid and mem_rd drop; a pending capture is discarded (no MISR update).
  - abort wins over a same-cycle cap_ready.
- abort in IDLE is ignored. start outside IDLE is ignored.
- dut_in, signature and vec_cnt hold their values after a run ends until the next start.

## Timing
- Reset values: all outputs 0, except signature=SEED; state is IDLE.
- Latencies, with cap_ready tied high:
  - start to first mem_rd: 1 cycle.
  - mem_rd to dut_in update: 1 cycle.
  - Per vector: 3+settle cycles (FETCH, LOAD, settle×SETTLE, CAPTURE).
- Run length: the last handshake is followed by a done pulse on the next cycle. Total run is 1 + num_vec·num_loops·(3+settle) + 1 cycles.
- dut_out is sampled settle+1 cycles after dut_in changes. This bounds the DUT combinational delay.
- Backpressure: each cycle cap_ready is low adds exactly one cycle. dut_in is held stable throughout.
- Empty run: start with num_vec==0 gives done 2 cycles after start. No mem_rd is issued and signature stays SEED.
- Reset mid-run: immediate return to reset values. No done or aborted pulse.

## Structure
- A shared package holds the state enum and the default constants: VEC_W/OUT_W for c5315, POLY, SEED.
- One sub-module, vec_misr: parameterized fold plus 32-bit MISR with clear and enable. The FSM, counters and registers stay in vec_sequencer.

## Test plan
- Basic run: num_vec=3, num_loops=1, settle=2, cap_ready=1, pass-through DUT. Required: 3 captures equal to mem[0..2]; done at cycle 17 after start; vec_cnt=3; signature matches the reference MISR model.
- Looping: num_vec=2, num_loops=3, settle=0. Required: addresses 0,1,0,1,0,1; vec_cnt=6; done 20 cycles after start.
- Backpressure: cap_ready low for 4 cycles on the 2nd vector. Required: cap_valid/cap_data and dut_in stable across the stall; done 4 cycles later than the unstalled run.
- Empty run: num_vec=0. Required: no mem_rd; done pulses 2 cycles after start; signature=32'hFFFFFFFF.
- Abort: abort asserted in CAPTURE with cap_ready=1 in the same cycle. Required: IDLE next cycle, aborted=1, done=0, vec_cnt not incremented, busy=0.
- Reset mid-SETTLE: rst pulse. Required: all outputs at reset values; a following start runs normally from addr 0.
